// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA 640x480@60 timing constants, derived totals,
//                sync window bounds and screen size for renderers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   localparam int COORD_W     = 10;
   localparam int FRAME_CNT_W = 16;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam bit SYNC_POL = 1'b0;

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int SCREEN_X = H_ACTIVE;
   localparam int SCREEN_Y = V_ACTIVE;

endpackage

`default_nettype wire

// File: rtl/vga_timing_if.sv
// ============================================================================
//  Module      : vga_timing_if
//  Description : Raster position/sync bundle between timing block and
//                its consumers (renderers, compositor).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_if;
   import vga_pkg::*;

   logic                   pix_en;
   logic [COORD_W-1:0]     x;
   logic [COORD_W-1:0]     y;
   logic                   active;
   logic                   hsync;
   logic                   vsync;
   logic                   line_start;
   logic                   frame_start;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   modport master (
      input  pix_en,
      output x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
   );

   modport slave (
      output pix_en,
      input  x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
   );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Wrapping position counter for one raster axis with
//                terminal count and registered sync/active window decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int ACT_END    = H_ACTIVE,
   parameter int SYNC_START = H_SYNC_START,
   parameter int SYNC_END   = H_SYNC_END,
   parameter bit POL        = SYNC_POL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   output logic [COORD_W-1:0] count,
   output logic               tc,
   output logic               act,
   output logic               sync
);

   localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] ACT_C   = COORD_W'(ACT_END);
   localparam logic [COORD_W-1:0] SS_C    = COORD_W'(SYNC_START);
   localparam logic [COORD_W-1:0] SE_C    = COORD_W'(SYNC_END);
   localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

   logic [COORD_W-1:0] count_nxt;
   logic               act_nxt;
   logic               sync_nxt;

   assign tc = (count == LAST);

   // Window decode works on the next count so act/sync land with the position.
   always_comb begin
      count_nxt = count;
      if (inc) begin
         count_nxt = tc ? '0 : count + ONE;
      end
      act_nxt  = (count_nxt < ACT_C);
      sync_nxt = ((count_nxt >= SS_C) && (count_nxt < SE_C)) ? POL : ~POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         act   <= 1'b1;
         sync  <= ~POL;
      end else begin
         count <= count_nxt;
         act   <= act_nxt;
         sync  <= sync_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster timing generator: x/y position, syncs, active
//                flag, line/frame start pulses and completed-frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing
   import vga_pkg::COORD_W, vga_pkg::FRAME_CNT_W;
#(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter bit SYNC_POL = vga_pkg::SYNC_POL
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master bus
);

   localparam int H_TOTAL_L = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL_L = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SS_L    = H_ACTIVE + H_FP;
   localparam int V_SS_L    = V_ACTIVE + V_FP;

   logic [COORD_W-1:0]     h_count;
   logic [COORD_W-1:0]     v_count;
   logic                   h_tc;
   logic                   v_tc;
   logic                   h_act;
   logic                   v_act;
   logic                   h_sync;
   logic                   v_sync;
   logic                   v_inc;
   logic                   line_start_q;
   logic                   frame_start_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   // The vertical axis steps only on the enabled cycle that wraps the line.
   assign v_inc = bus.pix_en & h_tc;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL_L),
      .ACT_END    (H_ACTIVE),
      .SYNC_START (H_SS_L),
      .SYNC_END   (H_SS_L + H_SYNC),
      .POL        (SYNC_POL)
   ) u_h_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.pix_en),
      .count (h_count),
      .tc    (h_tc),
      .act   (h_act),
      .sync  (h_sync)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL_L),
      .ACT_END    (V_ACTIVE),
      .SYNC_START (V_SS_L),
      .SYNC_END   (V_SS_L + V_SYNC),
      .POL        (SYNC_POL)
   ) u_v_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (v_inc),
      .count (v_count),
      .tc    (v_tc),
      .act   (v_act),
      .sync  (v_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         line_start_q  <= v_inc;
         frame_start_q <= v_inc & v_tc;
         if (v_inc && v_tc) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
         end
      end
   end

   assign bus.x           = h_count;
   assign bus.y           = v_count;
   assign bus.active      = h_act & v_act;
   assign bus.hsync       = h_sync;
   assign bus.vsync       = v_sync;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Self-checking bench for vga_timing (default and reduced
//                geometry instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_timing_if m_if ();
   vga_timing_if s_if ();

   vga_timing dut_m (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if)
   );

   // Small geometry: 10 x 6 total, hsync x=6..8, vsync y=3..4, 60 steps/frame
   vga_timing #(
      .H_ACTIVE (4), .H_FP (2), .H_SYNC (3), .H_BP (1),
      .V_ACTIVE (2), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .SYNC_POL (1'b0)
   ) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s_if)
   );

   int checks = 0;
   int errors = 0;
   int ms = 0;
   int ss = 0;
   bit m_last = 1'b0;
   bit s_last = 1'b0;

   typedef struct {
      bit en;
      int x;
      int y;
      bit act;
      bit hs;
      bit vs;
      bit ls;
      bit fs;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick(input bit m_en, input bit s_en);
      m_if.pix_en = m_en;
      s_if.pix_en = s_en;
      @(posedge clk);
      #1;
      m_last = m_en;
      s_last = s_en;
      if (m_en) ms++;
      if (s_en) ss++;
   endtask

   task automatic check_main();
      int ex, ey;
      ex = ms % 800;
      ey = (ms / 800) % 525;
      chk("m.x", int'(m_if.x), ex);
      chk("m.y", int'(m_if.y), ey);
      chk("m.active", int'(m_if.active), int'(ex < 640 && ey < 480));
      chk("m.hsync", int'(m_if.hsync), int'(!(ex >= 656 && ex < 752)));
      chk("m.vsync", int'(m_if.vsync), int'(!(ey >= 490 && ey < 492)));
      chk("m.line_start", int'(m_if.line_start), int'(m_last && ex == 0));
      chk("m.frame_start", int'(m_if.frame_start), int'(m_last && ex == 0 && ey == 0));
      chk("m.frame_cnt", int'(m_if.frame_cnt), ms / 420000);
   endtask

   task automatic check_small();
      int ex, ey;
      ex = ss % 10;
      ey = (ss / 10) % 6;
      chk("s.x", int'(s_if.x), ex);
      chk("s.y", int'(s_if.y), ey);
      chk("s.active", int'(s_if.active), int'(ex < 4 && ey < 2));
      chk("s.hsync", int'(s_if.hsync), int'(!(ex >= 6 && ex < 9)));
      chk("s.vsync", int'(s_if.vsync), int'(!(ey >= 3 && ey < 5)));
      chk("s.line_start", int'(s_if.line_start), int'(s_last && ex == 0));
      chk("s.frame_start", int'(s_if.frame_start), int'(s_last && ex == 0 && ey == 0));
      chk("s.frame_cnt", int'(s_if.frame_cnt), ss / 60);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".m.x"}, int'(m_if.x), 0);
      chk({tag, ".m.y"}, int'(m_if.y), 0);
      chk({tag, ".m.active"}, int'(m_if.active), 1);
      chk({tag, ".m.hsync"}, int'(m_if.hsync), 1);
      chk({tag, ".m.vsync"}, int'(m_if.vsync), 1);
      chk({tag, ".m.frame_cnt"}, int'(m_if.frame_cnt), 0);
      chk({tag, ".s.x"}, int'(s_if.x), 0);
      chk({tag, ".s.y"}, int'(s_if.y), 0);
      chk({tag, ".s.active"}, int'(s_if.active), 1);
      chk({tag, ".s.line_start"}, int'(s_if.line_start), 0);
      chk({tag, ".s.frame_start"}, int'(s_if.frame_start), 0);
   endtask

   initial begin
      int cnt, first_ls, ls_cyc0, ls_cyc1, cyc;
      bit seen;

      //            en  x  y act hs vs ls fs
      vecs[0]  = '{1, 1, 0, 1, 1, 1, 0, 0};
      vecs[1]  = '{0, 1, 0, 1, 1, 1, 0, 0};
      vecs[2]  = '{1, 2, 0, 1, 1, 1, 0, 0};
      vecs[3]  = '{1, 3, 0, 1, 1, 1, 0, 0};
      vecs[4]  = '{1, 4, 0, 0, 1, 1, 0, 0};
      vecs[5]  = '{1, 5, 0, 0, 1, 1, 0, 0};
      vecs[6]  = '{1, 6, 0, 0, 0, 1, 0, 0};
      vecs[7]  = '{0, 6, 0, 0, 0, 1, 0, 0};
      vecs[8]  = '{1, 7, 0, 0, 0, 1, 0, 0};
      vecs[9]  = '{1, 8, 0, 0, 0, 1, 0, 0};
      vecs[10] = '{1, 9, 0, 0, 1, 1, 0, 0};
      vecs[11] = '{1, 0, 1, 1, 1, 1, 1, 0};
      vecs[12] = '{0, 0, 1, 1, 1, 1, 0, 0};
      vecs[13] = '{1, 1, 1, 1, 1, 1, 0, 0};

      m_if.pix_en = 1'b0;
      s_if.pix_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;

      // Idle after release: everything holds at reset values
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0);
         check_main();
         check_small();
      end

      // Table-driven first line of the small geometry
      for (int i = 0; i < 14; i++) begin
         tick(1'b0, vecs[i].en);
         chk($sformatf("vec%0d.x", i), int'(s_if.x), vecs[i].x);
         chk($sformatf("vec%0d.y", i), int'(s_if.y), vecs[i].y);
         chk($sformatf("vec%0d.active", i), int'(s_if.active), int'(vecs[i].act));
         chk($sformatf("vec%0d.hsync", i), int'(s_if.hsync), int'(vecs[i].hs));
         chk($sformatf("vec%0d.vsync", i), int'(s_if.vsync), int'(vecs[i].vs));
         chk($sformatf("vec%0d.line_start", i), int'(s_if.line_start), int'(vecs[i].ls));
         chk($sformatf("vec%0d.frame_start", i), int'(s_if.frame_start), int'(vecs[i].fs));
      end

      // Two small frames continuous: vsync window, frame_start, frame_cnt
      cnt = 0;
      for (int i = 0; i < 120; i++) begin
         tick(1'b0, 1'b1);
         check_small();
         if (i < 60 && s_if.vsync == 1'b0) cnt++;
      end
      chk("s.vsync_low_steps", cnt, 20);

      // Default geometry, continuous: first two lines
      cnt = 0;
      first_ls = 0;
      for (int i = 0; i < 1700; i++) begin
         tick(1'b1, 1'b0);
         check_main();
         if (i < 800 && m_if.hsync == 1'b0) cnt++;
         if (m_if.line_start) first_ls++;
      end
      chk("m.hsync_low_steps", cnt, 96);
      chk("m.line_start_count", first_ls, 2);

      // Half-rate enable: each position held two clocks, line period 1600 clks
      cnt = 0;
      ls_cyc0 = -1;
      ls_cyc1 = -1;
      cyc = 0;
      for (int i = 0; i < 3400; i++) begin
         tick((i % 2) == 0, 1'b0);
         cyc++;
         check_main();
         if (m_if.line_start) begin
            cnt++;
            if (ls_cyc0 < 0) ls_cyc0 = cyc;
            else ls_cyc1 = cyc;
         end
      end
      chk("m.toggle_ls_count", cnt, 2);
      chk("m.toggle_line_period", ls_cyc1 - ls_cyc0, 1600);

      // Mid-frame asynchronous reset on small geometry at (3,2)
      while ((ss % 60) != 23) begin
         tick(1'b0, 1'b1);
      end
      chk("s.pre_reset_x", int'(s_if.x), 3);
      chk("s.pre_reset_y", int'(s_if.y), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      chk("async_rst.s.hsync", int'(s_if.hsync), 1);
      chk("async_rst.s.frame_cnt", int'(s_if.frame_cnt), 0);
      m_if.pix_en = 1'b0;
      s_if.pix_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ms = 0;
      ss = 0;
      m_last = 1'b0;
      s_last = 1'b0;
      for (int i = 0; i < 65; i++) begin
         tick(1'b0, 1'b1);
         check_small();
      end

      // frame_cnt wrap 65535 -> 0 on the next frame_start
      force dut_s.frame_cnt_q = 16'hFFFF;
      #1;
      release dut_s.frame_cnt_q;
      chk("wrap.preload", int'(s_if.frame_cnt), 65535);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick(1'b0, 1'b1);
         if (s_if.frame_start) seen = 1'b1;
         else chk("wrap.hold", int'(s_if.frame_cnt), 65535);
      end
      chk("wrap.frame_start_seen", int'(seen), 1);
      chk("wrap.frame_cnt", int'(s_if.frame_cnt), 0);
      chk("wrap.x", int'(s_if.x), 0);
      chk("wrap.y", int'(s_if.y), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
